// File: rtl/nios2_jtag_scan_pkg.sv
// nios2_jtag_scan_pkg
//   Shared definitions for the Nios II virtual-JTAG scan master:
//   scan FSM state encoding and default DR/IR widths and TCK divider.
//   Optional feature macro used by the master: JTAG_SCAN_SKIP_IR_EN.
package nios2_jtag_scan_pkg;

    localparam int unsigned DEF_DR_WIDTH = 38;
    localparam int unsigned DEF_IR_WIDTH = 2;
    localparam int unsigned DEF_TCK_DIV  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RESP
    } scan_state_e;

endpackage

// File: rtl/nios2_jtag_scan_tck_gen.sv
// nios2_jtag_scan_tck_gen
//   Divides clk down to the virtual TCK. One tck period is 2*TCK_DIV clk:
//   low for the first TCK_DIV clk, high for the second.
// Ports
//   clk        in  system clock
//   reset_n    in  synchronous active-low reset
//   en_i       in  advance the divider
//   clr_i      in  force divider and tck back to period start (tck low)
//   tck_o      out generated TCK
//   tck_rise_o out high on the clk whose rising edge drives tck high
//   tck_fall_o out high on the clk whose rising edge drives tck low
//                  (end of the current tck period)
module nios2_jtag_scan_tck_gen
    import nios2_jtag_scan_pkg::*;
#(
    parameter int unsigned TCK_DIV = DEF_TCK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tck_o,
    output logic tck_rise_o,
    output logic tck_fall_o
);

    // $clog2(1) is zero; keep at least one bit so TCK_DIV=1 still elaborates.
    localparam int unsigned CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CW-1:0] div_q, div_d;
    logic          tck_q, tck_d;
    logic          wrap;

    always_comb begin
        div_d = div_q;
        tck_d = tck_q;
        wrap  = (div_q == CW'(TCK_DIV - 1));
        if (clr_i) begin
            div_d = '0;
            tck_d = 1'b0;
        end else if (en_i) begin
            if (wrap) begin
                div_d = '0;
                tck_d = ~tck_q;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q <= '0;
            tck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            tck_q <= tck_d;
        end
    end

    assign tck_o      = tck_q;
    assign tck_rise_o = en_i & ~clr_i & wrap & ~tck_q;
    assign tck_fall_o = en_i & ~clr_i & wrap &  tck_q;

endmodule

// File: rtl/nios2_jtag_scan_master.sv
// nios2_jtag_scan_master
//   Initiator end of the Nios II virtual-JTAG debug link. Each accepted
//   command performs UIR -> CDR -> SDR(DR_WIDTH bits) -> UDR -> RTI on the
//   vji_* interface, then presents the captured tdo bits and ir_out.
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_ir, cmd_dr latched on accept
//   rsp_valid/rsp_ready     response handshake; rsp_dr (bit0 = first bit
//                           shifted), rsp_ir_out (vji_ir_out sampled in UIR)
//   vji_tck, vji_tdi        generated TCK and serial data to target
//   vji_tdo, vji_ir_out     serial data and IR status from target
//   vji_ir_in               virtual IR, held from UIR through RTI
//   vji_uir/cdr/sdr/udr/rti virtual state strobes, one-hot or all zero
// Configuration
//   JTAG_SCAN_SKIP_IR_EN    when defined, a command whose IR matches the
//                           previous one skips UIR and rsp_ir_out repeats
//                           the last sampled value.
module nios2_jtag_scan_master
    import nios2_jtag_scan_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DEF_DR_WIDTH,
    parameter int unsigned IR_WIDTH = DEF_IR_WIDTH,
    parameter int unsigned TCK_DIV  = DEF_TCK_DIV
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int unsigned BCW = $clog2(DR_WIDTH + 1);

    scan_state_e         state_q, state_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DR_WIDTH-1:0] tdi_sr_q, tdi_sr_d;
    logic [DR_WIDTH-1:0] rdr_q, rdr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] rir_q, rir_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                accept, skip_ir, busy, tck_clr;
    logic                tck_rise, tck_fall;
`ifdef JTAG_SCAN_SKIP_IR_EN
    logic [IR_WIDTH-1:0] last_ir_q, last_ir_d;
    logic                last_vld_q, last_vld_d;
`endif

    assign busy    = state_q inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI};
    assign tck_clr = ~busy;

    nios2_jtag_scan_tck_gen #(
        .TCK_DIV(TCK_DIV)
    ) u_tck_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (busy),
        .clr_i     (tck_clr),
        .tck_o     (vji_tck),
        .tck_rise_o(tck_rise),
        .tck_fall_o(tck_fall)
    );

    // State advances only on tck_fall, i.e. at the start of a new tck period,
    // so strobes, ir_in and tdi all change at the tck falling point.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tdi_sr_d  = tdi_sr_q;
        rdr_d     = rdr_q;
        ir_d      = ir_q;
        rir_d     = rir_q;
        accept    = cmd_valid & cmd_ready_q;
        skip_ir   = 1'b0;
`ifdef JTAG_SCAN_SKIP_IR_EN
        last_ir_d  = last_ir_q;
        last_vld_d = last_vld_q;
        skip_ir    = last_vld_q && (cmd_ir == last_ir_q);
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ir_d      = cmd_ir;
                    tdi_sr_d  = cmd_dr;
                    bit_cnt_d = '0;
                    state_d   = skip_ir ? ST_CDR : ST_UIR;
`ifdef JTAG_SCAN_SKIP_IR_EN
                    last_ir_d  = cmd_ir;
                    last_vld_d = 1'b1;
`endif
                end
            end
            ST_UIR: begin
                if (tck_rise) rir_d = vji_ir_out;
                if (tck_fall) state_d = ST_CDR;
            end
            ST_CDR: begin
                if (tck_fall) state_d = ST_SDR;
            end
            ST_SDR: begin
                // tdo enters at the MSB; after DR_WIDTH shifts the first
                // captured bit has reached bit 0.
                if (tck_rise) rdr_d = {vji_tdo, rdr_q[DR_WIDTH-1:1]};
                if (tck_fall) begin
                    tdi_sr_d = tdi_sr_q >> 1;
                    if (bit_cnt_q == BCW'(DR_WIDTH - 1)) begin
                        state_d = ST_UDR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_UDR: begin
                if (tck_fall) state_d = ST_RTI;
            end
            ST_RTI: begin
                if (tck_fall) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so cmd_ready is low during reset and rises one clk after.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            tdi_sr_q    <= '0;
            rdr_q       <= '0;
            ir_q        <= '0;
            rir_q       <= '0;
            cmd_ready_q <= 1'b0;
`ifdef JTAG_SCAN_SKIP_IR_EN
            last_ir_q   <= '0;
            last_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tdi_sr_q    <= tdi_sr_d;
            rdr_q       <= rdr_d;
            ir_q        <= ir_d;
            rir_q       <= rir_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef JTAG_SCAN_SKIP_IR_EN
            last_ir_q   <= last_ir_d;
            last_vld_q  <= last_vld_d;
`endif
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_dr     = rdr_q;
    assign rsp_ir_out = rir_q;
    assign vji_tdi    = (state_q == ST_SDR) & tdi_sr_q[0];
    assign vji_ir_in  = busy ? ir_q : '0;
    assign vji_uir    = (state_q == ST_UIR);
    assign vji_cdr    = (state_q == ST_CDR);
    assign vji_sdr    = (state_q == ST_SDR);
    assign vji_udr    = (state_q == ST_UDR);
    assign vji_rti    = (state_q == ST_RTI);

endmodule

// File: tb/tb_nios2_jtag_scan_master.sv
// tb_nios2_jtag_scan_master
//   Scoreboard bench for nios2_jtag_scan_master: a default instance
//   (TCK_DIV=4) driven against a small target model, plus a TCK_DIV=1
//   instance for the fast-clock latency case.
module tb_nios2_jtag_scan_master;

    localparam int DR       = 38;
    localparam int IR       = 2;
    localparam int LAT_FULL = (DR + 4) * 2 * 4;
    localparam int LAT_SKIP = (DR + 3) * 2 * 4;
    localparam int LAT_DIV1 = (DR + 4) * 2;

    typedef struct {
        logic [DR-1:0] dr;
        logic [IR-1:0] ir;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0 (TCK_DIV = 4) ----------------
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [IR-1:0] cmd_ir = '0;
    logic [DR-1:0] cmd_dr = '0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [DR-1:0] rsp_dr;
    logic [IR-1:0] rsp_ir_out;
    logic          vji_tck, vji_tdi, vji_tdo;
    logic [IR-1:0] vji_ir_in, vji_ir_out;
    logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    nios2_jtag_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    // Target model: captures tgt_data in CDR, shifts it out LSB first in SDR,
    // and records tdi bits and the number of SDR rising edges.
    logic [DR-1:0] tgt_data = '0;
    logic [DR-1:0] tgt_sr   = '0;
    logic [IR-1:0] tgt_ir   = '0;
    logic [DR-1:0] tdi_cap  = '0;
    int            sdr_rise = 0;
    int            uir_cnt  = 0;

    assign vji_tdo    = tgt_sr[0];
    assign vji_ir_out = tgt_ir;

    always @(posedge vji_tck) begin
        if (vji_cdr) begin
            tgt_sr   = tgt_data;
            tdi_cap  = '0;
            sdr_rise = 0;
        end else if (vji_sdr) begin
            tdi_cap  = {vji_tdi, tdi_cap[DR-1:1]};
            tgt_sr   = tgt_sr >> 1;
            sdr_rise = sdr_rise + 1;
        end
    end

    always @(posedge vji_uir) uir_cnt = uir_cnt + 1;

    // ---------------- DUT 1 (TCK_DIV = 1) ----------------
    logic          cmd_valid1 = 1'b0, cmd_ready1;
    logic [IR-1:0] cmd_ir1 = '0;
    logic [DR-1:0] cmd_dr1 = '0;
    logic          rsp_valid1, rsp_ready1 = 1'b0;
    logic [DR-1:0] rsp_dr1;
    logic [IR-1:0] rsp_ir_out1;
    logic          vji_tck1, vji_tdi1;
    logic          vji_tdo1 = 1'b1;
    logic [IR-1:0] vji_ir_in1;
    logic [IR-1:0] vji_ir_out1 = 2'b01;
    logic          vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1;
    int            tck1_cnt = 0;

    nios2_jtag_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir1), .cmd_dr(cmd_dr1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_dr(rsp_dr1), .rsp_ir_out(rsp_ir_out1),
        .vji_tck(vji_tck1), .vji_tdi(vji_tdi1), .vji_tdo(vji_tdo1),
        .vji_ir_in(vji_ir_in1), .vji_ir_out(vji_ir_out1),
        .vji_uir(vji_uir1), .vji_cdr(vji_cdr1), .vji_sdr(vji_sdr1), .vji_udr(vji_udr1), .vji_rti(vji_rti1)
    );

    always @(posedge vji_tck1) tck1_cnt = tck1_cnt + 1;

    // ---------------- stimulus helpers (called #1 after a posedge) ----------------
    task automatic issue(input logic [IR-1:0] ir, input logic [DR-1:0] dr);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_ir    = ir;
        cmd_dr    = dr;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 2000);
        if (rsp_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0",
                     {cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
        end
        n_checks++;
        if ({rsp_dr, rsp_ir_out, vji_ir_in} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: rsp_dr=%h rsp_ir_out=%b vji_ir_in=%b required 0", rsp_dr, rsp_ir_out, vji_ir_in);
        end
        reset_n = 1'b1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: cmd_ready=%b required 0", cmd_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_release: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_scan();
        logic [IR-1:0] irs[3];
        logic [DR-1:0] drs[3];
        logic [DR-1:0] tds[3];
        logic [IR-1:0] tis[3];
        int            lat;
        exp_t          e;
        irs[0] = 2'b01; drs[0] = 38'h15_5555_5555; tds[0] = 38'h2A_AAAA_AAAA; tis[0] = 2'b10;
        irs[1] = 2'b10; drs[1] = '1;               tds[1] = '0;               tis[1] = 2'b01;
        irs[2] = 2'b00; drs[2] = {$urandom(), 6'($urandom())};
        tds[2] = {6'($urandom()), $urandom()};     tis[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tgt_data = tds[i];
            tgt_ir   = tis[i];
            sb.push_back('{dr: tds[i], ir: tis[i]});
            issue(irs[i], drs[i]);
            n_checks++;
            if ({cmd_ready, vji_uir, vji_ir_in, vji_tck} !== {1'b0, 1'b1, irs[i], 1'b0}) begin
                n_fail++;
                $display("FAIL scan%0d_start: ready/uir/ir_in/tck=%b required %b", i,
                         {cmd_ready, vji_uir, vji_ir_in, vji_tck}, {1'b0, 1'b1, irs[i], 1'b0});
            end
            wait_rsp(lat);
            e = sb.pop_front();
            n_checks++;
            if (lat != LAT_FULL) begin
                n_fail++;
                $display("FAIL scan%0d_latency: got %0d required %0d", i, lat, LAT_FULL);
            end
            n_checks++;
            if (rsp_dr !== e.dr || rsp_ir_out !== e.ir) begin
                n_fail++;
                $display("FAIL scan%0d_rsp: dr=%h ir=%b required dr=%h ir=%b", i, rsp_dr, rsp_ir_out, e.dr, e.ir);
            end
            n_checks++;
            if (sdr_rise != DR || tdi_cap !== drs[i]) begin
                n_fail++;
                $display("FAIL scan%0d_tdi: rises=%0d tdi=%h required rises=%0d tdi=%h", i, sdr_rise, tdi_cap, DR, drs[i]);
            end
            n_checks++;
            if ({vji_ir_in, vji_tck} !== '0) begin
                n_fail++;
                $display("FAIL scan%0d_idle_bus: ir_in=%b tck=%b required 0", i, vji_ir_in, vji_tck);
            end
            consume();
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL scan%0d_consume: rsp_valid=%b required 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int   lat, uir0;
        exp_t e;
        tgt_data = 38'h0F_1234_5678;
        tgt_ir   = 2'b10;
        sb.push_back('{dr: 38'h0F_1234_5678, ir: 2'b10});
        issue(2'b11, 38'h3C_CCCC_3333);
        wait_rsp(lat);
        e    = sb.pop_front();
        uir0 = uir_cnt;
        cmd_valid = 1'b1;
        cmd_ir    = 2'b00;
        cmd_dr    = '1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_dr !== e.dr || rsp_ir_out !== e.ir || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_c%0d: valid=%b dr=%h ir=%b ready=%b required 1 %h %b 0",
                         i, rsp_valid, rsp_dr, rsp_ir_out, cmd_ready, e.dr, e.ir);
            end
        end
        cmd_valid = 1'b0;
        consume();
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || uir_cnt != uir0) begin
            n_fail++;
            $display("FAIL backpressure_no_second: valid=%b ready=%b uir_pulses=%0d required 0 1 0",
                     rsp_valid, cmd_ready, uir_cnt - uir0);
        end
        // rsp_ready while idle must not disturb anything
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_rsp_ready: valid=%b ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_scan();
        int   n, seen, lat;
        exp_t e;
        tgt_data = 38'h33_0000_FFFF;
        tgt_ir   = 2'b01;
        sb.push_back('{dr: 38'h33_0000_FFFF, ir: 2'b01});
        issue(2'b01, 38'h00_FFFF_0000);
        n = 0;
        while (!(vji_sdr === 1'b1 && sdr_rise == 20) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (!(vji_sdr === 1'b1 && sdr_rise == 20)) begin
            n_fail++;
            $display("FAIL mid_reached_bit20: sdr=%b rises=%0d required 1 20", vji_sdr, sdr_rise);
        end
        reset_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        n_checks++;
        if ({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, rsp_valid, vji_ir_in} !== '0) begin
            n_fail++;
            $display("FAIL mid_abort: tck/tdi/strobes/valid/ir_in=%b required 0",
                     {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, rsp_valid, vji_ir_in});
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || vji_tck !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mid_no_rsp: active cycles=%0d required 0", seen);
        end
        tgt_data = 38'h12_3456_789A;
        tgt_ir   = 2'b11;
        sb.push_back('{dr: 38'h12_3456_789A, ir: 2'b11});
        issue(2'b01, 38'h2B_CDEF_0123);
        wait_rsp(lat);
        e = sb.pop_front();
        n_checks++;
        if (rsp_dr !== e.dr || rsp_ir_out !== e.ir || lat != LAT_FULL || tdi_cap !== 38'h2B_CDEF_0123) begin
            n_fail++;
            $display("FAIL mid_rescan: dr=%h ir=%b lat=%0d tdi=%h required %h %b %0d %h",
                     rsp_dr, rsp_ir_out, lat, tdi_cap, e.dr, e.ir, LAT_FULL, 38'h2B_CDEF_0123);
        end
        consume();
    endtask

    task automatic test_skip_ir();
        int   uir0, lat1, lat2, exp_uir, exp_lat2;
        exp_t e;
`ifdef JTAG_SCAN_SKIP_IR_EN
        exp_uir  = 1;
        exp_lat2 = LAT_SKIP;
`else
        exp_uir  = 2;
        exp_lat2 = LAT_FULL;
`endif
        uir0     = uir_cnt;
        tgt_data = 38'h01_0203_0405;
        tgt_ir   = 2'b10;
        sb.push_back('{dr: 38'h01_0203_0405, ir: 2'b10});
        issue(2'b11, 38'h3F_0000_0001);
        wait_rsp(lat1);
        e = sb.pop_front();
        n_checks++;
        if (rsp_dr !== e.dr || rsp_ir_out !== e.ir || lat1 != LAT_FULL) begin
            n_fail++;
            $display("FAIL skip_first: dr=%h ir=%b lat=%0d required %h %b %0d", rsp_dr, rsp_ir_out, lat1, e.dr, e.ir, LAT_FULL);
        end
        consume();
        tgt_data = 38'h2F_EDCB_A987;
        tgt_ir   = 2'b01;
`ifdef JTAG_SCAN_SKIP_IR_EN
        sb.push_back('{dr: 38'h2F_EDCB_A987, ir: 2'b10});
`else
        sb.push_back('{dr: 38'h2F_EDCB_A987, ir: 2'b01});
`endif
        issue(2'b11, 38'h15_0F0F_F0F0);
        wait_rsp(lat2);
        e = sb.pop_front();
        n_checks++;
        if (rsp_dr !== e.dr || rsp_ir_out !== e.ir || lat2 != exp_lat2) begin
            n_fail++;
            $display("FAIL skip_second: dr=%h ir=%b lat=%0d required %h %b %0d", rsp_dr, rsp_ir_out, lat2, e.dr, e.ir, exp_lat2);
        end
        n_checks++;
        if (uir_cnt - uir0 != exp_uir) begin
            n_fail++;
            $display("FAIL skip_uir_pulses: got %0d required %0d", uir_cnt - uir0, exp_uir);
        end
        consume();
    endtask

    task automatic test_latency_div1();
        int lat, t0, n;
        n = 0;
        while (cmd_ready1 !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        t0         = tck1_cnt;
        cmd_ir1    = 2'b10;
        cmd_dr1    = 38'h2A_5A5A_5A5A;
        cmd_valid1 = 1'b1;
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (rsp_valid1 !== 1'b1 && lat < 500);
        n_checks++;
        if (lat != LAT_DIV1 || rsp_valid1 !== 1'b1) begin
            n_fail++;
            $display("FAIL div1_latency: got %0d valid=%b required %0d 1", lat, rsp_valid1, LAT_DIV1);
        end
        n_checks++;
        if (rsp_dr1 !== '1 || rsp_ir_out1 !== 2'b01 || tck1_cnt - t0 != DR + 4) begin
            n_fail++;
            $display("FAIL div1_rsp: dr=%h ir=%b tck_rises=%0d required all-ones 01 %0d",
                     rsp_dr1, rsp_ir_out1, tck1_cnt - t0, DR + 4);
        end
        n_checks++;
        if ({vji_tck1, vji_tdi1, vji_ir_in1, vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1, cmd_ready1} !== '0) begin
            n_fail++;
            $display("FAIL div1_idle_bus: %b required 0",
                     {vji_tck1, vji_tdi1, vji_ir_in1, vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1, cmd_ready1});
        end
        rsp_ready1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_backpressure();
        test_latency_div1();
        test_reset_mid_scan();
        test_skip_ir();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
